// File: rtl/decode_issue.sv
// decode_issue: RV32 decode/issue stage for a small ALU subset (add/sub/and/or
// and their immediate forms). It has a 32x32 register file with write-back
// bypass and a single registered issue bundle with a valid/ready handshake.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   instr_valid/instr_ready    upstream handshake (instr_ready is combinational)
//   instr                      RV32 instruction word
//   wb_en, wb_rd, wb_data      register write-back port (x0 writes ignored)
//   issue_valid/issue_ready    downstream handshake towards the ALU
//   operand_a, operand_b       ALU operands (operand_b = rs2 or I-immediate)
//   function_3, function_7     ALU function code and modifier
//   issue_rd, issue_rd_we      destination index and write enable
//   illegal                    one-cycle pulse for an accepted undecodable word
module decode_issue (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [31:0] instr,
    input  logic        wb_en,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    output logic        issue_valid,
    input  logic        issue_ready,
    output logic [31:0] operand_a,
    output logic [31:0] operand_b,
    output logic [2:0]  function_3,
    output logic [6:0]  function_7,
    output logic [4:0]  issue_rd,
    output logic        issue_rd_we,
    output logic        illegal
);

    localparam int unsigned XLEN   = 32;
    localparam int unsigned REG_AW = 5;
    localparam int unsigned NREGS  = 32;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_AND  = 3'b111;
    localparam logic [2:0] F3_OR   = 3'b110;

    // Instruction fields
    logic [6:0]        opcode;
    logic [REG_AW-1:0] rd;
    logic [2:0]        f3;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [6:0]        f7;

    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign f3     = instr[14:12];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];
    assign f7     = instr[31:25];

    // Register file; entry 0 is never written and therefore stays zero
    logic [XLEN-1:0] regs [NREGS];

    logic            wb_write;
    assign wb_write = wb_en && (wb_rd != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_write) begin
            regs[wb_rd] <= wb_data;
        end
    end

    // Decode legality and operand selection for the word at the input
    logic            is_r;
    logic            is_i;
    logic            legal;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] op_b_nxt;
    logic [6:0]      f7_nxt;

    always_comb begin
        is_r  = 1'b0;
        is_i  = 1'b0;
        legal = 1'b0;
        unique case (opcode)
            OP_R: begin
                is_r  = 1'b1;
                legal = ((f3 == F3_ADD) && ((f7 == F7_BASE) || (f7 == F7_ALT))) ||
                        (((f3 == F3_AND) || (f3 == F3_OR)) && (f7 == F7_BASE));
            end
            OP_I: begin
                is_i  = 1'b1;
                legal = (f3 == F3_ADD) || (f3 == F3_AND) || (f3 == F3_OR);
            end
            default: begin
                legal = 1'b0;
            end
        endcase
    end

    // A write-back landing in the same cycle is forwarded, since the array
    // only sees it on the next edge
    always_comb begin
        rs1_val = '0;
        rs2_val = '0;
        if (rs1 != '0) begin
            rs1_val = (wb_write && (wb_rd == rs1)) ? wb_data : regs[rs1];
        end
        if (rs2 != '0) begin
            rs2_val = (wb_write && (wb_rd == rs2)) ? wb_data : regs[rs2];
        end
    end

    assign imm_i    = {{(XLEN - 12){instr[31]}}, instr[31:20]};
    assign op_b_nxt = is_i ? imm_i : rs2_val;
    assign f7_nxt   = is_r ? f7 : F7_BASE;

    // Single output register: accept when empty or being drained this cycle
    logic accept;
    assign instr_ready = !issue_valid || issue_ready;
    assign accept      = instr_valid && instr_ready;

    // Issue bundle register; fields only change on a legal accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_valid <= 1'b0;
            illegal     <= 1'b0;
            operand_a   <= '0;
            operand_b   <= '0;
            function_3  <= '0;
            function_7  <= '0;
            issue_rd    <= '0;
            issue_rd_we <= 1'b0;
        end else begin
            illegal <= accept && !legal;
            if (accept) begin
                issue_valid <= legal;
                if (legal) begin
                    operand_a   <= rs1_val;
                    operand_b   <= op_b_nxt;
                    function_3  <= f3;
                    function_7  <= f7_nxt;
                    issue_rd    <= rd;
                    issue_rd_we <= (rd != '0);
                end
            end else if (issue_ready) begin
                issue_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_decode_issue.sv
// tb_decode_issue: directed scenarios plus randomized traffic checked against
// a behavioural model of the decode/issue stage.
module tb_decode_issue;

    logic        clk;
    logic        rst_n;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        issue_valid;
    logic        issue_ready;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic [2:0]  function_3;
    logic [6:0]  function_7;
    logic [4:0]  issue_rd;
    logic        issue_rd_we;
    logic        illegal;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] ADD_X3_X1_X2  = 32'h002081B3;
    localparam logic [31:0] ADDI_X4_X1_M1 = 32'hFFF08213;
    localparam logic [31:0] SLL_X3_X1_X2  = 32'h002091B3;
    localparam logic [31:0] LW_X5_X1      = 32'h0000A283;
    localparam logic [31:0] SUB_X5_X1_X2  = 32'h402082B3;
    localparam logic [31:0] ADD_X3_X1_X0  = 32'h000081B3;

    decode_issue dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .wb_en       (wb_en),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .issue_valid (issue_valid),
        .issue_ready (issue_ready),
        .operand_a   (operand_a),
        .operand_b   (operand_b),
        .function_3  (function_3),
        .function_7  (function_7),
        .issue_rd    (issue_rd),
        .issue_rd_we (issue_rd_we),
        .illegal     (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic v, input logic [31:0] w, input logic we,
                         input logic [4:0] r, input logic [31:0] d, input logic ir);
        instr_valid = v;
        instr       = w;
        wb_en       = we;
        wb_rd       = r;
        wb_data     = d;
        issue_ready = ir;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1);
        repeat (2) @(negedge clk);
        checks++;
        if (issue_valid !== 1'b0 || illegal !== 1'b0 || operand_a !== 32'h0 || operand_b !== 32'h0 ||
            function_3 !== 3'h0 || function_7 !== 7'h0 || issue_rd !== 5'h0 || issue_rd_we !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: valid=%0b ill=%0b a=%h b=%h f3=%h f7=%h rd=%0d we=%0b expected all zero",
                     issue_valid, illegal, operand_a, operand_b, function_3, function_7, issue_rd, issue_rd_we);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (instr_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: instr_ready=%0b expected 1", instr_ready);
        end
    endtask

    task automatic test_add_addi();
        @(negedge clk); drive(1'b0, 32'h0, 1'b1, 5'd1, 32'd5, 1'b1);
        @(negedge clk); drive(1'b0, 32'h0, 1'b1, 5'd2, 32'd3, 1'b1);
        @(negedge clk); drive(1'b1, ADD_X3_X1_X2, 1'b0, 5'd0, 32'h0, 1'b1);
        @(negedge clk);
        checks++;
        if (issue_valid !== 1'b1 || operand_a !== 32'd5 || operand_b !== 32'd3 || function_3 !== 3'b000 ||
            function_7 !== 7'b0000000 || issue_rd !== 5'd3 || issue_rd_we !== 1'b1) begin
            errors++;
            $display("FAIL add_bundle: valid=%0b a=%0d b=%0d f3=%b f7=%b rd=%0d we=%0b expected 1 5 3 000 0000000 3 1",
                     issue_valid, operand_a, operand_b, function_3, function_7, issue_rd, issue_rd_we);
        end
        drive(1'b1, ADDI_X4_X1_M1, 1'b0, 5'd0, 32'h0, 1'b1);
        #1;
        checks++;
        if (instr_ready !== 1'b1) begin
            errors++;
            $display("FAIL add_ready_when_draining: instr_ready=%0b expected 1", instr_ready);
        end
        @(negedge clk);
        checks++;
        if (issue_valid !== 1'b1 || operand_a !== 32'd5 || operand_b !== 32'hFFFFFFFF || function_3 !== 3'b000 ||
            function_7 !== 7'b0000000 || issue_rd !== 5'd4 || issue_rd_we !== 1'b1) begin
            errors++;
            $display("FAIL addi_bundle: valid=%0b a=%h b=%h f3=%b f7=%b rd=%0d we=%0b expected 1 5 ffffffff 000 0000000 4 1",
                     issue_valid, operand_a, operand_b, function_3, function_7, issue_rd, issue_rd_we);
        end
        drive(1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1);
        @(negedge clk);
        checks++;
        if (issue_valid !== 1'b0) begin
            errors++;
            $display("FAIL addi_drain: issue_valid=%0b expected 0", issue_valid);
        end
    endtask

    task automatic test_stall();
        drive(1'b1, ADD_X3_X1_X2, 1'b0, 5'd0, 32'h0, 1'b0);
        @(negedge clk);
        drive(1'b1, ADDI_X4_X1_M1, 1'b0, 5'd0, 32'h0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (instr_ready !== 1'b0 || issue_valid !== 1'b1 || operand_a !== 32'd5 || operand_b !== 32'd3 ||
                issue_rd !== 5'd3 || function_7 !== 7'h0) begin
                errors++;
                $display("FAIL stall_hold[%0d]: ready=%0b valid=%0b a=%0d b=%0d rd=%0d f7=%b expected 0 1 5 3 3 0000000",
                         i, instr_ready, issue_valid, operand_a, operand_b, issue_rd, function_7);
            end
            @(negedge clk);
        end
        issue_ready = 1'b1;
        #1;
        checks++;
        if (instr_ready !== 1'b1) begin
            errors++;
            $display("FAIL stall_release_ready: instr_ready=%0b expected 1", instr_ready);
        end
        @(negedge clk);
        checks++;
        if (issue_valid !== 1'b1 || issue_rd !== 5'd4 || operand_b !== 32'hFFFFFFFF) begin
            errors++;
            $display("FAIL stall_back_to_back: valid=%0b rd=%0d b=%h expected 1 4 ffffffff",
                     issue_valid, issue_rd, operand_b);
        end
        drive(1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1);
        @(negedge clk);
    endtask

    task automatic test_illegal_bypass();
        drive(1'b1, SLL_X3_X1_X2, 1'b0, 5'd0, 32'h0, 1'b1);
        @(negedge clk);
        checks++;
        if (illegal !== 1'b1 || issue_valid !== 1'b0) begin
            errors++;
            $display("FAIL illegal_sll: illegal=%0b valid=%0b expected 1 0", illegal, issue_valid);
        end
        drive(1'b1, LW_X5_X1, 1'b0, 5'd0, 32'h0, 1'b1);
        @(negedge clk);
        checks++;
        if (illegal !== 1'b1 || issue_valid !== 1'b0) begin
            errors++;
            $display("FAIL illegal_load: illegal=%0b valid=%0b expected 1 0", illegal, issue_valid);
        end
        drive(1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1);
        @(negedge clk);
        checks++;
        if (illegal !== 1'b0) begin
            errors++;
            $display("FAIL illegal_one_cycle: illegal=%0b expected 0", illegal);
        end
        drive(1'b1, SUB_X5_X1_X2, 1'b1, 5'd1, 32'd9, 1'b1);
        @(negedge clk);
        checks++;
        if (issue_valid !== 1'b1 || operand_a !== 32'd9 || operand_b !== 32'd3 || function_3 !== 3'b000 ||
            function_7 !== 7'b0100000 || issue_rd !== 5'd5 || issue_rd_we !== 1'b1) begin
            errors++;
            $display("FAIL sub_bypass: valid=%0b a=%0d b=%0d f3=%b f7=%b rd=%0d we=%0b expected 1 9 3 000 0100000 5 1",
                     issue_valid, operand_a, operand_b, function_3, function_7, issue_rd, issue_rd_we);
        end
        // Illegal word accepted while the sub bundle drains
        drive(1'b1, LW_X5_X1, 1'b0, 5'd0, 32'h0, 1'b1);
        @(negedge clk);
        checks++;
        if (issue_valid !== 1'b0 || illegal !== 1'b1) begin
            errors++;
            $display("FAIL illegal_while_draining: valid=%0b illegal=%0b expected 0 1", issue_valid, illegal);
        end
        drive(1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1);
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        drive(1'b1, ADD_X3_X1_X2, 1'b0, 5'd0, 32'h0, 1'b0);
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
        checks++;
        if (issue_valid !== 1'b1 || operand_a !== 32'd9) begin
            errors++;
            $display("FAIL async_pre: valid=%0b a=%0d expected 1 9", issue_valid, operand_a);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (issue_valid !== 1'b0 || operand_a !== 32'h0 || operand_b !== 32'h0 || issue_rd !== 5'h0) begin
            errors++;
            $display("FAIL async_reset: valid=%0b a=%h b=%h rd=%0d expected 0 0 0 0",
                     issue_valid, operand_a, operand_b, issue_rd);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (instr_ready !== 1'b1) begin
            errors++;
            $display("FAIL async_ready_after: instr_ready=%0b expected 1", instr_ready);
        end
        drive(1'b1, ADD_X3_X1_X0, 1'b0, 5'd0, 32'h0, 1'b1);
        @(negedge clk);
        checks++;
        if (issue_valid !== 1'b1 || operand_a !== 32'h0 || operand_b !== 32'h0) begin
            errors++;
            $display("FAIL async_x1_cleared: valid=%0b a=%h b=%h expected 1 0 0", issue_valid, operand_a, operand_b);
        end
        drive(1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1);
        @(negedge clk);
        checks++;
        if (issue_valid !== 1'b0) begin
            errors++;
            $display("FAIL async_drain: issue_valid=%0b expected 0", issue_valid);
        end
    endtask

    // Reference model: register contents and the bundle the ALU should see
    logic [31:0] m_regs [32];
    logic        m_valid;
    logic        m_ill;
    logic [31:0] m_a;
    logic [31:0] m_b;
    logic [2:0]  m_f3;
    logic [6:0]  m_f7;
    logic [4:0]  m_rd;

    function automatic bit m_legal(input logic [31:0] w);
        int op = int'(w[6:0]);
        int f3 = int'(w[14:12]);
        int f7 = int'(w[31:25]);
        if (op == 'h33) return (f3 == 0 && (f7 == 0 || f7 == 32)) || ((f3 == 7 || f3 == 6) && f7 == 0);
        if (op == 'h13) return (f3 == 0 || f3 == 7 || f3 == 6);
        return 1'b0;
    endfunction

    function automatic logic [31:0] m_read(input int r, input logic we, input int wr, input logic [31:0] wd);
        if (r == 0) return 32'h0;
        if (we && wr == r) return wd;
        return m_regs[r];
    endfunction

    task automatic test_random(input int n);
        logic [31:0] w;
        logic [6:0]  op;
        logic [6:0]  f7;
        int          imm;
        logic        rdy;
        for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
        m_valid = 1'b0;
        m_ill   = 1'b0;
        m_a = '0; m_b = '0; m_f3 = '0; m_f7 = '0; m_rd = '0;
        for (int c = 0; c < n; c++) begin
            checks++;
            if (issue_valid !== m_valid || illegal !== m_ill) begin
                errors++;
                $display("FAIL rand_status[%0d]: valid=%0b illegal=%0b expected %0b %0b",
                         c, issue_valid, illegal, m_valid, m_ill);
            end
            if (m_valid) begin
                checks++;
                if (operand_a !== m_a || operand_b !== m_b || function_3 !== m_f3 || function_7 !== m_f7 ||
                    issue_rd !== m_rd || issue_rd_we !== (m_rd != 5'd0)) begin
                    errors++;
                    $display("FAIL rand_bundle[%0d]: a=%h b=%h f3=%b f7=%b rd=%0d we=%0b expected %h %h %b %b %0d %0b",
                             c, operand_a, operand_b, function_3, function_7, issue_rd, issue_rd_we,
                             m_a, m_b, m_f3, m_f7, m_rd, (m_rd != 5'd0));
                end
            end
            case ($urandom_range(0, 3))
                0: op = 7'h33;
                1: op = 7'h13;
                2: op = 7'h03;
                default: op = 7'($urandom);
            endcase
            case ($urandom_range(0, 2))
                0: f7 = 7'h00;
                1: f7 = 7'h20;
                default: f7 = 7'($urandom);
            endcase
            w = {f7, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                 5'($urandom_range(0, 7)), op};
            drive(1'($urandom_range(0, 3) != 0), w, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                  $urandom, 1'($urandom_range(0, 3) != 0));
            #1;
            rdy = !m_valid || issue_ready;
            checks++;
            if (instr_ready !== rdy) begin
                errors++;
                $display("FAIL rand_ready[%0d]: instr_ready=%0b expected %0b", c, instr_ready, rdy);
            end
            m_ill = 1'b0;
            if (instr_valid && rdy) begin
                if (m_legal(w)) begin
                    m_valid = 1'b1;
                    m_a  = m_read(int'(w[19:15]), wb_en, int'(wb_rd), wb_data);
                    m_f3 = w[14:12];
                    m_rd = w[11:7];
                    if (w[6:0] == 7'h13) begin
                        imm = int'(w[31:20]);
                        if (imm >= 2048) imm = imm - 4096;
                        m_b  = 32'(imm);
                        m_f7 = 7'h00;
                    end else begin
                        m_b  = m_read(int'(w[24:20]), wb_en, int'(wb_rd), wb_data);
                        m_f7 = w[31:25];
                    end
                end else begin
                    m_valid = 1'b0;
                    m_ill   = 1'b1;
                end
            end else if (issue_ready) begin
                m_valid = 1'b0;
            end
            if (wb_en && wb_rd != 5'd0) m_regs[wb_rd] = wb_data;
            @(negedge clk);
        end
        drive(1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1);
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_add_addi();
        test_stall();
        test_illegal_bypass();
        test_async_reset();
        test_random(400);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
